rr_bus_arbiter4: RTL and testbench
==================================

Name: rr_bus_arbiter4

Overview:
- Round-robin arbiter for four 8-bit sources that share the datapath bus.
- Sits directly upstream of the 8-bit 4:1 bus multiplexer and drives its 2-bit select, so the winning source's d0..d3 word appears on the mux output y.
- Grants are held for a bounded burst, then handed to the next requester with no idle bubble.
- Also produces a one-hot grant back to the sources and a bus-valid qualifier for the consumer of y.

Parameters:
- BURST_MAX, 4, maximum consecutive cycles one source may hold the bus (legal range 1..15).
- CNT_W, 4, width of the burst counter; must satisfy 2**CNT_W > BURST_MAX.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset (sampled on rising clk edge).
- req  input  4  request per source; req[i] set means source i wants the bus.
- sel  output 2  registered select for the downstream mux s input (00=d0 .. 11=d3).
- gnt  output 4  registered one-hot grant; all-zero when idle.
- busy output 1  registered; 1 while a grant is held (state GRANT).
- bus_valid output 1  combinational; busy & req[sel]; the consumer captures y only when set.

Behaviour:
- State: IDLE and GRANT. Other state is the priority pointer ptr[1:0] (highest-priority index) and the burst counter cnt[CNT_W-1:0].
- Reset (rst=1 at an edge, any state, including mid-burst):
  - state=IDLE, sel=0, gnt=0000, busy=0, cnt=0, ptr=0.
  - bus_valid is therefore 0 the cycle after reset.
- Pick function: scans req starting at ptr, ascending with wrap (ptr, ptr+1, ... mod 4). It returns the first set index and an any flag.
- IDLE:
  - If any req is set at the edge: next state=GRANT, sel=winner, gnt=onehot(winner), busy=1, cnt=1, ptr=winner+1 mod 4.
  - Otherwise remain IDLE; outputs unchanged (zero).
  - Latency: req high at edge N gives gnt at edge N (visible in the cycle after edge N). This is one registered cycle.
- GRANT: the release condition is req[sel]==0 OR cnt==BURST_MAX.
  - No release: stay in GRANT, sel/gnt unchanged, cnt+1. ptr unchanged.
  - Release with any other req pending (pick from ptr): switch directly to the new winner in the next cycle, with no IDLE cycle. Load cnt=1 and ptr=winner+1.
  - Release due to burst expiry while the current holder still requests and no other req is set: the search wraps to the holder itself. It is re-granted with cnt=1. The sel/gnt values do not change.
  - Release with no req set at all: go to IDLE, gnt=0000, busy=0, cnt=0.
  - sel holds its last value in IDLE, so the mux output is stable. Consumers must rely on bus_valid, not on sel.
- Holder drops req: gnt stays asserted one more cycle. bus_valid drops in the same cycle as req (it is combinational), so no stale word is captured.
- A new request arriving at a lower index than ptr is not served before higher-pointer requesters. Fairness guarantee: every continuously asserted req is granted within 3*BURST_MAX+1 cycles.
- gnt is always one-hot or zero. sel always equals the index of gnt when busy=1.
- cnt never exceeds BURST_MAX and never wraps.
- No X propagation: all registers are reset. An X on req while busy=0 needs no special handling; it is a verification error.

Decomposition:
- Shared package (bus_pkg):
  - Constants NREQ=4, SEL_W=2, DATA_W=8.
  - State encoding IDLE=1'b0, GRANT=1'b1.
  - These are also consumed by the mux and register stages.
- One natural sub-module, rr_pick4: combinational. Inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and any. It is reused by the top for both IDLE acquisition and GRANT handoff.
- The top holds the FSM, counter, pointer and output registers.
- Expected size about 150-220 lines total.

Test Plan:
- Reset/idle: assert rst for 2 cycles with req=1111 → gnt=0000, sel=00, busy=0. After release with req=1111 held, the next cycle gives gnt=0001, sel=00, busy=1, bus_valid=1.
- Burst rotation: req=1111 held constant with BURST_MAX=4 → gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001… with zero idle cycles between holders.
- Early release: source 2 alone (req=0100) is granted. Drop req[2] after 2 cycles while req=0001 → bus_valid=0 the same cycle, then gnt=0001, sel=00 next cycle, cnt=1.
- Sole holder expiry: req=1000 held for 10 cycles → gnt=1000 continuously, busy never drops, cnt pattern 1,2,3,4,1,2,3,4,1,2.
- Pointer fairness: after source 1 is granted (ptr=2), assert req=0011 → source 0 waits. When source 1 releases, source 0 is granted next. Source 1 re-requesting immediately is not granted before source 0's burst ends.
- Reset mid-burst: during a grant to source 3 with cnt=2, pulse rst one cycle with req=1111 → the next edge gives gnt=0000, ptr=0. The following edge gives gnt=0001.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus constants, arbiter state encoding and helpers.
// Also consumed by the bus mux and register stages.
package bus_pkg;

    localparam int NREQ   = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // One-hot grant vector for a source index.
    function automatic logic [NREQ-1:0] onehot(
        input logic [SEL_W-1:0] i
    );
        return NREQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority pick: first set req scanning up from ptr,
// wrapping modulo 4. Purely combinational.
module rr_pick4
    import bus_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // Scan from farthest offset down so the nearest hit wins.
    always_comb begin
        logic [SEL_W-1:0] j;
        idx = ptr;
        any = 1'b0;
        j   = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = ptr + SEL_W'(k);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Round-robin arbiter for four bus sources with bounded bursts.
// Drives the 4:1 bus mux select plus one-hot grant and bus_valid.
module rr_bus_arbiter4
    import bus_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             bus_valid
);

    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             rel;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Holder gives up the bus when it stops asking or its burst is spent.
    assign rel = ~req[sel_q] | (cnt_q == BURST_CNT);

    // Next-state: acquire from IDLE, extend, hand off or go idle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    busy_d  = 1'b1;
                    cnt_d   = CNT_ONE;
                    ptr_d   = pick_idx + 2'd1;
                end
            end
            GRANT: begin
                if (!rel) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (pick_any) begin
                    // Direct handoff; may re-grant the holder itself.
                    sel_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    cnt_d   = CNT_ONE;
                    ptr_d   = pick_idx + 2'd1;
                end else begin
                    // sel is kept so the mux output stays stable.
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign bus_valid = busy_q & req[sel_q];

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Scoreboard bench for rr_bus_arbiter4 (BURST_MAX=4).
// Directed vectors push expected outputs; a monitor pops and compares.
module tb_rr_bus_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       bus_valid;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       bv;
    } obs_t;

    typedef struct {
        int   id;
        obs_t exp;
    } sb_t;

    sb_t exp_q[$];
    int  n_cmp;
    int  n_bad;
    int  vec_id;

    rr_bus_arbiter4 #(
        .BURST_MAX (4),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .gnt       (gnt),
        .busy      (busy),
        .bus_valid (bus_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs; push the outputs expected after that edge.
    task automatic step(
        input logic       r,
        input logic [3:0] rq,
        input logic [3:0] eg,
        input logic [1:0] es,
        input logic       eb
    );
        sb_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        vec_id++;
        e.id       = vec_id;
        e.exp.gnt  = eg;
        e.exp.sel  = es;
        e.exp.busy = eb;
        e.exp.bv   = eb & rq[es];
        exp_q.push_back(e);
    endtask

    // Monitor: compare registered outputs just after each rising edge.
    initial begin
        sb_t  e;
        obs_t act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = '{gnt, sel, busy, bus_valid};
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL vec%0d: got gnt=%b sel=%0d busy=%b bv=%b, want gnt=%b sel=%0d busy=%b bv=%b",
                             e.id, act.gnt, act.sel, act.busy, act.bv,
                             e.exp.gnt, e.exp.sel, e.exp.busy, e.exp.bv);
                end
            end
        end
    end

    initial begin
        int waited;
        n_cmp  = 0;
        n_bad  = 0;
        vec_id = 0;
        rst    = 1'b1;
        req    = 4'b0000;

        // Reset held two cycles with all requesting.
        step(1, 4'b1111, 4'b0000, 2'd0, 0);
        step(1, 4'b1111, 4'b0000, 2'd0, 0);
        // Rotation: each holder keeps the bus 4 cycles.
        step(0, 4'b1111, 4'b0001, 2'd0, 1);
        step(0, 4'b1111, 4'b0001, 2'd0, 1);
        step(0, 4'b1111, 4'b0001, 2'd0, 1);
        step(0, 4'b1111, 4'b0001, 2'd0, 1);
        step(0, 4'b1111, 4'b0010, 2'd1, 1);
        step(0, 4'b1111, 4'b0010, 2'd1, 1);
        step(0, 4'b1111, 4'b0010, 2'd1, 1);
        step(0, 4'b1111, 4'b0010, 2'd1, 1);
        step(0, 4'b1111, 4'b0100, 2'd2, 1);
        step(0, 4'b1111, 4'b0100, 2'd2, 1);
        step(0, 4'b1111, 4'b0100, 2'd2, 1);
        step(0, 4'b1111, 4'b0100, 2'd2, 1);
        step(0, 4'b1111, 4'b1000, 2'd3, 1);
        step(0, 4'b1111, 4'b1000, 2'd3, 1);
        step(0, 4'b1111, 4'b1000, 2'd3, 1);
        step(0, 4'b1111, 4'b1000, 2'd3, 1);
        step(0, 4'b1111, 4'b0001, 2'd0, 1);
        // Early release: source 2 alone, then drops for source 0.
        step(0, 4'b0100, 4'b0100, 2'd2, 1);
        step(0, 4'b0100, 4'b0100, 2'd2, 1);
        step(0, 4'b0001, 4'b0001, 2'd0, 1);
        // Before that edge: grant still 0100 but bus_valid already low.
        #1;
        n_cmp++;
        if (!(gnt === 4'b0100 && bus_valid === 1'b0)) begin
            n_bad++;
            $display("FAIL drop_bv: got gnt=%b bv=%b, want gnt=0100 bv=0",
                     gnt, bus_valid);
        end
        // Sole holder: source 3 for 10 cycles, re-granted on expiry.
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        // No requests: idle, sel keeps its last value.
        step(0, 4'b0000, 4'b0000, 2'd3, 0);
        step(0, 4'b0000, 4'b0000, 2'd3, 0);
        // Pointer fairness around source 1 and source 0.
        step(0, 4'b0010, 4'b0010, 2'd1, 1);
        step(0, 4'b0011, 4'b0010, 2'd1, 1);
        step(0, 4'b0001, 4'b0001, 2'd0, 1);
        step(0, 4'b0011, 4'b0001, 2'd0, 1);
        step(0, 4'b0011, 4'b0001, 2'd0, 1);
        step(0, 4'b0011, 4'b0001, 2'd0, 1);
        step(0, 4'b0011, 4'b0010, 2'd1, 1);
        // Reset mid-burst of source 3 (cnt=2).
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1);
        step(1, 4'b1111, 4'b0000, 2'd0, 0);
        step(0, 4'b1111, 4'b0001, 2'd0, 1);
        step(0, 4'b1111, 4'b0001, 2'd0, 1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
